spi_ram_arbiter: RTL and testbench

SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

---
 rtl/spi_ram_arbiter_if.sv | 38 +++
 rtl/spi_ram_arbiter.sv | 146 ++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_arbiter_if.sv
// Signal bundle between spi_ram_arbiter and its SPI front-end, host and single-port RAM.
// slave is the arbiter side; master is the surrounding SPI/host/RAM side.
interface spi_ram_arbiter_if #(
  parameter int unsigned ADDR_SIZE = 8
);
  logic [ADDR_SIZE+1:0] rx_data;
  logic                 rx_valid;
  logic [ADDR_SIZE-1:0] tx_data;
  logic                 tx_valid;

  logic                 host_req;
  logic                 host_we;
  logic [ADDR_SIZE-1:0] host_addr;
  logic [ADDR_SIZE-1:0] host_wdata;
  logic                 host_gnt;
  logic                 host_rvalid;
  logic [ADDR_SIZE-1:0] host_rdata;

  logic                 ram_en;
  logic                 ram_we;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [ADDR_SIZE-1:0] ram_din;
  logic [ADDR_SIZE-1:0] ram_dout;

  logic                 spi_ovf;

  modport slave (
    input  rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, ram_dout,
    output tx_data, tx_valid, host_gnt, host_rvalid, host_rdata,
    output ram_en, ram_we, ram_addr, ram_din, spi_ovf
  );

  modport master (
    output rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, ram_dout,
    input  tx_data, tx_valid, host_gnt, host_rvalid, host_rdata,
    input  ram_en, ram_we, ram_addr, ram_din, spi_ovf
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Arbitrates a single-port RAM between SPI command words and a host port.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise SPI always wins.
module spi_ram_arbiter #(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input logic               clk,
  input logic               rst_n,
  spi_ram_arbiter_if.slave  bus_io
);

  if (MEM_DEPTH > (2 ** ADDR_SIZE)) begin : g_depth_chk
    $error("MEM_DEPTH exceeds the address space");
  end

  typedef enum logic [2:0] {StIdle, StSpiAcc, StHostAcc, StSpiRdWait, StHostRdWait} state_e;

  state_e                state_q;
  logic                  rx_valid_q;
  logic [ADDR_SIZE-1:0]  wr_addr_q, rd_addr_q;
  logic                  pend_vld_q, pend_rd_q;
  logic [ADDR_SIZE-1:0]  pend_addr_q, pend_data_q;
  logic [ADDR_SIZE-1:0]  tx_data_q, host_rdata_q, ram_addr_q, ram_din_q;
  logic                  tx_valid_q, host_gnt_q, host_rvalid_q, ram_en_q, ram_we_q, spi_ovf_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic                  last_host_q;
`endif

  logic [1:0]            rx_op;
  logic [ADDR_SIZE-1:0]  rx_payload;
  logic                  capture, pend_free, pend_load, spi_ovf_set, spi_wins;

  assign rx_op      = bus_io.rx_data[ADDR_SIZE+1:ADDR_SIZE];
  assign rx_payload = bus_io.rx_data[ADDR_SIZE-1:0];
  assign capture    = bus_io.rx_valid & ~rx_valid_q;
  // The pending slot empties on the closing edge of SPI_ACC, so a word landing there is kept.
  assign pend_free   = (state_q == StSpiAcc);
  assign pend_load   = capture & rx_op[0] & (~pend_vld_q | pend_free);
  assign spi_ovf_set = capture & rx_op[0] & pend_vld_q & ~pend_free;

`ifdef ARB_ROUND_ROBIN_EN
  assign spi_wins = pend_vld_q & (~bus_io.host_req | last_host_q);
`else
  assign spi_wins = pend_vld_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      rx_valid_q    <= 1'b0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      pend_vld_q    <= 1'b0;
      pend_rd_q     <= 1'b0;
      pend_addr_q   <= '0;
      pend_data_q   <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      host_gnt_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      spi_ovf_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_host_q   <= 1'b1;
`endif
    end else begin
      rx_valid_q    <= bus_io.rx_valid;
      host_gnt_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;

      if (capture) begin
        tx_valid_q <= 1'b0;
        if (rx_op == 2'b00) wr_addr_q <= rx_payload;
        if (rx_op == 2'b10) rd_addr_q <= rx_payload;
      end

      if (pend_load) begin
        pend_vld_q  <= 1'b1;
        pend_rd_q   <= rx_op[1];
        pend_addr_q <= rx_op[1] ? rd_addr_q : wr_addr_q;
        pend_data_q <= rx_payload;
      end else if (pend_free) begin
        pend_vld_q  <= 1'b0;
      end

      if (spi_ovf_set) spi_ovf_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (spi_wins) begin
            state_q    <= StSpiAcc;
            ram_en_q   <= 1'b1;
            ram_we_q   <= ~pend_rd_q;
            ram_addr_q <= pend_addr_q;
            ram_din_q  <= pend_data_q;
`ifdef ARB_ROUND_ROBIN_EN
            last_host_q <= 1'b0;
`endif
          end else if (bus_io.host_req) begin
            state_q    <= StHostAcc;
            ram_en_q   <= 1'b1;
            ram_we_q   <= bus_io.host_we;
            ram_addr_q <= bus_io.host_addr;
            ram_din_q  <= bus_io.host_wdata;
            host_gnt_q <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_host_q <= 1'b1;
`endif
          end
        end
        StSpiAcc:  state_q <= ram_we_q ? StIdle : StSpiRdWait;
        StHostAcc: state_q <= ram_we_q ? StIdle : StHostRdWait;
        StSpiRdWait: begin
          // Fresh read data wins over a capture clearing tx_valid on the same edge.
          tx_data_q  <= bus_io.ram_dout;
          tx_valid_q <= 1'b1;
          state_q    <= StIdle;
        end
        StHostRdWait: begin
          host_rdata_q  <= bus_io.ram_dout;
          host_rvalid_q <= 1'b1;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.tx_data     = tx_data_q;
  assign bus_io.tx_valid    = tx_valid_q;
  assign bus_io.host_gnt    = host_gnt_q;
  assign bus_io.host_rvalid = host_rvalid_q;
  assign bus_io.host_rdata  = host_rdata_q;
  assign bus_io.ram_en      = ram_en_q;
  assign bus_io.ram_we      = ram_we_q;
  assign bus_io.ram_addr    = ram_addr_q;
  assign bus_io.ram_din     = ram_din_q;
  assign bus_io.spi_ovf     = spi_ovf_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: directed scenarios then random SPI/host traffic,
// every cycle compared against an edge-scheduled transaction model.
module tb_spi_ram_arbiter;
  localparam int unsigned AddrSize = 8;
  localparam int unsigned MemDepth = 256;

  logic clk;
  logic rst_n;
  spi_ram_arbiter_if #(.ADDR_SIZE(AddrSize)) bus ();

  spi_ram_arbiter #(.ADDR_SIZE(AddrSize), .MEM_DEPTH(MemDepth)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: read data appears the cycle after the access.
  logic [7:0] ram_mem [MemDepth];
  logic       ram_init_done = 1'b0;
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < MemDepth; i++) ram_mem[i] <= 8'((i * 7 + 3) & 8'hFF);
      ram_init_done <= 1'b1;
    end else if (bus.ram_en) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
      else            bus.ram_dout <= ram_mem[bus.ram_addr];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         mdl_n, mdl_next_dec, mdl_spi_edge, mdl_spi_rd_edge, mdl_host_rd_edge;
  logic       mdl_pend_v, mdl_pend_rd, mdl_last_host, mdl_prev_rx, mdl_mw_pend;
  logic [7:0] mdl_pend_addr, mdl_pend_data, mdl_wr_addr, mdl_rd_addr;
  logic [7:0] mdl_spi_rd_val, mdl_host_rd_val, mdl_mw_addr, mdl_mw_data;
  logic [7:0] mdl_mem [MemDepth];
  logic       e_ram_en, e_ram_we, e_gnt, e_rvalid, e_tx_valid, e_ovf;
  logic [7:0] e_ram_addr, e_ram_din, e_rdata, e_tx_data;

  logic log_en = 1'b0;
  int   dut_served_q[$];
  int   mdl_served_q[$];
  int   ram_wr_cnt = 0;

  task automatic model_reset();
    mdl_n = 0; mdl_next_dec = 0;
    mdl_spi_edge = -10; mdl_spi_rd_edge = -10; mdl_host_rd_edge = -10;
    mdl_pend_v = 0; mdl_pend_rd = 0; mdl_pend_addr = 0; mdl_pend_data = 0;
    mdl_wr_addr = 0; mdl_rd_addr = 0; mdl_last_host = 1; mdl_prev_rx = 0; mdl_mw_pend = 0;
    e_ram_en = 0; e_ram_we = 0; e_gnt = 0; e_rvalid = 0; e_tx_valid = 0; e_ovf = 0;
    e_ram_addr = 0; e_ram_din = 0; e_rdata = 0; e_tx_data = 0;
  endtask

  // Start a RAM access decided on edge n; a write lands in RAM on the following edge.
  task automatic model_access(input int n, input logic we, input logic [7:0] a,
                              input logic [7:0] d);
    e_ram_en = 1; e_ram_we = we; e_ram_addr = a; e_ram_din = d;
    if (we) begin
      mdl_mw_pend = 1; mdl_mw_addr = a; mdl_mw_data = d;
      mdl_next_dec = n + 2;
    end else begin
      mdl_next_dec = n + 3;
    end
  endtask

  task automatic model_step();
    int n;
    logic capture, freeing, spi_wins;
    logic [1:0] op;
    logic [7:0] pl;
    n = mdl_n;
    if (mdl_mw_pend) begin
      mdl_mem[mdl_mw_addr] = mdl_mw_data;
      mdl_mw_pend = 0;
    end
    capture = bus.rx_valid && !mdl_prev_rx;
    op = bus.rx_data[9:8];
    pl = bus.rx_data[7:0];
    freeing = mdl_pend_v && (mdl_spi_edge == n - 1);
    e_ram_en = 0; e_ram_we = 0; e_gnt = 0; e_rvalid = 0;
    if (n >= mdl_next_dec) begin
`ifdef ARB_ROUND_ROBIN_EN
      spi_wins = mdl_pend_v && (!bus.host_req || mdl_last_host);
`else
      spi_wins = mdl_pend_v;
`endif
      if (spi_wins) begin
        model_access(n, !mdl_pend_rd, mdl_pend_addr, mdl_pend_data);
        mdl_spi_edge = n;
        mdl_last_host = 0;
        if (mdl_pend_rd) begin
          mdl_spi_rd_edge = n + 2;
          mdl_spi_rd_val = mdl_mem[mdl_pend_addr];
        end
        if (log_en) mdl_served_q.push_back(0);
      end else if (bus.host_req) begin
        model_access(n, bus.host_we, bus.host_addr, bus.host_wdata);
        e_gnt = 1;
        mdl_last_host = 1;
        if (!bus.host_we) begin
          mdl_host_rd_edge = n + 2;
          mdl_host_rd_val = mdl_mem[bus.host_addr];
        end
        if (log_en) mdl_served_q.push_back(1);
      end
    end
    if (mdl_spi_rd_edge == n) begin
      e_tx_data = mdl_spi_rd_val;
      e_tx_valid = 1;
    end else if (capture) begin
      e_tx_valid = 0;
    end
    if (mdl_host_rd_edge == n) begin
      e_rvalid = 1;
      e_rdata = mdl_host_rd_val;
    end
    if (freeing) mdl_pend_v = 0;
    if (capture) begin
      if (op == 2'b00) mdl_wr_addr = pl;
      else if (op == 2'b10) mdl_rd_addr = pl;
      else if (mdl_pend_v) e_ovf = 1;
      else begin
        mdl_pend_v = 1;
        mdl_pend_rd = op[1];
        mdl_pend_addr = op[1] ? mdl_rd_addr : mdl_wr_addr;
        mdl_pend_data = pl;
      end
    end
    mdl_prev_rx = bus.rx_valid;
    mdl_n = n + 1;
  endtask

  task automatic check_outputs();
    check_eq("ram_en", bus.ram_en, e_ram_en);
    check_eq("ram_we", bus.ram_we, e_ram_we);
    check_eq("ram_addr", bus.ram_addr, e_ram_addr);
    check_eq("ram_din", bus.ram_din, e_ram_din);
    check_eq("host_gnt", bus.host_gnt, e_gnt);
    check_eq("host_rvalid", bus.host_rvalid, e_rvalid);
    check_eq("host_rdata", bus.host_rdata, e_rdata);
    check_eq("tx_valid", bus.tx_valid, e_tx_valid);
    check_eq("tx_data", bus.tx_data, e_tx_data);
    check_eq("spi_ovf", bus.spi_ovf, e_ovf);
  endtask

  // One clock: model on the rising edge, compare on the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_outputs();
    if (bus.ram_en && bus.ram_we) ram_wr_cnt++;
    if (log_en && bus.ram_en) dut_served_q.push_back((bus.ram_addr == 8'h40) ? 0 : 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic spi_word(input logic [9:0] w, input int hold);
    bus.rx_data = w;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < hold; i++) cyc();
    bus.rx_valid = 1'b0;
    cyc();
  endtask

  task automatic host_op(input logic we, input logic [7:0] a, input logic [7:0] d,
                         output int lat);
    bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (bus.host_gnt) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) check_eq("host_gnt_wait", bus.host_gnt, 1);
    bus.host_req = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle, released on a falling edge.
  task automatic reset_mid();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outputs();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic contend(input int round, input int exp_first);
    dut_served_q.delete();
    mdl_served_q.delete();
    log_en = 1'b1;
    bus.rx_data = 10'h15A;
    bus.rx_valid = 1'b1;
    cyc();
    bus.rx_valid = 1'b0;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h50; bus.host_wdata = 8'h66;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (bus.host_gnt) bus.host_req = 1'b0;
    end
    bus.host_req = 1'b0;
    log_en = 1'b0;
    check_eq($sformatf("contend%0d_count", round), dut_served_q.size(), 2);
    if (dut_served_q.size() > 0)
      check_eq($sformatf("contend%0d_first", round), dut_served_q[0], exp_first);
    check_eq($sformatf("contend%0d_vs_model", round),
             (dut_served_q == mdl_served_q) ? 1 : 0, 1);
  endtask

  int lat;
  int wr_before;
  int spi_hold, spi_gap;
  logic [7:0] pl;

  initial begin
    rst_n = 1'b0;
    bus.rx_data = '0; bus.rx_valid = 1'b0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    for (int i = 0; i < MemDepth; i++) mdl_mem[i] = 8'((i * 7 + 3) & 8'hFF);
    model_reset();
    idle(2);
    check_eq("reset_tx_valid", bus.tx_valid, 0);
    check_eq("reset_ram_addr", bus.ram_addr, 0);
    rst_n = 1'b1;
    idle(2);

    // SPI write of 0xA5 to 0x15
    spi_word(10'h015, 1);
    spi_word(10'h1A5, 1);
    check_eq("wr_ram_en", bus.ram_en, 1);
    check_eq("wr_ram_we", bus.ram_we, 1);
    check_eq("wr_ram_addr", bus.ram_addr, 8'h15);
    check_eq("wr_ram_din", bus.ram_din, 8'hA5);
    cyc();
    check_eq("wr_ram_en_drop", bus.ram_en, 0);
    check_eq("wr_addr_hold", bus.ram_addr, 8'h15);

    // SPI read back: tx_valid three edges after capture
    spi_word(10'h215, 1);
    spi_word(10'h300, 1);
    cyc();
    check_eq("rd_tx_valid_early", bus.tx_valid, 0);
    cyc();
    check_eq("rd_tx_valid", bus.tx_valid, 1);
    check_eq("rd_tx_data", bus.tx_data, 8'hA5);
    idle(3);
    check_eq("rd_tx_hold", bus.tx_valid, 1);

    // Host read of 0x15
    host_op(1'b0, 8'h15, 8'h00, lat);
    check_eq("host_gnt_latency", lat, 1);
    cyc();
    check_eq("host_rvalid_early", bus.host_rvalid, 0);
    cyc();
    check_eq("host_rvalid", bus.host_rvalid, 1);
    check_eq("host_rdata", bus.host_rdata, 8'hA5);
    cyc();
    check_eq("host_rvalid_pulse", bus.host_rvalid, 0);

    // Contention: first round after a host access, second after a lone SPI write
    spi_word(10'h040, 1);
    idle(2);
    contend(1, 0);
    spi_word(10'h111, 1);
    idle(4);
`ifdef ARB_ROUND_ROBIN_EN
    contend(2, 1);
`else
    contend(2, 0);
`endif
    idle(2);

    // Held rx_valid: one capture only; also exercises address 0xFF
    spi_word(10'h0FF, 1);
    wr_before = ram_wr_cnt;
    spi_word(10'h17E, 8);
    idle(4);
    check_eq("held_rx_one_write", ram_wr_cnt - wr_before, 1);
    host_op(1'b0, 8'hFF, 8'h00, lat);
    idle(2);
    check_eq("addr_ff_rdata", bus.host_rdata, 8'h7E);

    // Overflow: two SPI writes while the FSM is busy with a host read
    spi_word(10'h033, 1);
    idle(1);
    host_op(1'b0, 8'h20, 8'h00, lat);
    bus.rx_data = 10'h1C1; bus.rx_valid = 1'b1;
    cyc();
    bus.rx_valid = 1'b0;
    cyc();
    bus.rx_data = 10'h1C2; bus.rx_valid = 1'b1;
    cyc();
    bus.rx_valid = 1'b0;
    idle(5);
    check_eq("ovf_flag", bus.spi_ovf, 1);
    check_eq("ovf_first_only", ram_mem[8'h33], 8'hC1);

    // Reset during SPI_RD_WAIT
    spi_word(10'h233, 1);
    bus.rx_data = 10'h300; bus.rx_valid = 1'b1;
    cyc();
    bus.rx_valid = 1'b0;
    idle(2);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outputs();
    check_eq("rst_ram_en", bus.ram_en, 0);
    check_eq("rst_spi_ovf", bus.spi_ovf, 0);
    cyc();
    rst_n = 1'b1;
    idle(4);
    check_eq("rst_tx_valid_stays", bus.tx_valid, 0);
    spi_word(10'h233, 1);
    spi_word(10'h300, 1);
    idle(2);
    check_eq("post_rst_tx_valid", bus.tx_valid, 1);
    check_eq("post_rst_tx_data", bus.tx_data, 8'hC1);

    // Random traffic
    spi_hold = 0;
    spi_gap = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) reset_mid();
      if (bus.rx_valid) begin
        spi_hold--;
        if (spi_hold <= 0) bus.rx_valid = 1'b0;
      end else if (spi_gap > 0) begin
        spi_gap--;
      end else if ($urandom_range(0, 2) == 0) begin
        pl = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00)
                                         : 8'($urandom_range(0, 255));
        bus.rx_data = {2'($urandom_range(0, 3)), pl};
        bus.rx_valid = 1'b1;
        spi_hold = $urandom_range(1, 4);
        spi_gap = $urandom_range(0, 6);
      end
      if (bus.host_req && bus.host_gnt) begin
        bus.host_req = 1'b0;
      end else if (!bus.host_req && $urandom_range(0, 3) == 0) begin
        bus.host_req = 1'b1;
        bus.host_we = 1'($urandom_range(0, 1));
        bus.host_addr = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
        bus.host_wdata = 8'($urandom_range(0, 255));
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
